// File: rtl/seq_control_if.sv
// Microinstruction-side bus of the sequencer controller: the opcode, condition and
// counter inputs coming from the pipeline register, and the sequencer control lines going back.
interface seq_control_if #(
  parameter int CNT_W = 8
);
  // No valid/ready handshake: every field is sampled on each rising clock edge,
  // and the control lines are combinational from the current uop/cond and the registered state.
  logic [3:0]       uop;
  logic             cond;
  logic [CNT_W-1:0] cnt_in;
  logic             resume;
  logic             s0;
  logic             s1;
  logic             zero;
  logic             cin;
  logic             re;
  logic             fe;
  logic             pup;

  modport master (
    output uop, cond, cnt_in, resume,
    input  s0, s1, zero, cin, re, fe, pup
  );

  modport slave (
    input  uop, cond, cnt_in, resume,
    output s0, s1, zero, cin, re, fe, pup
  );
endinterface

// File: rtl/seq_control.sv
// Next-address controller for a microprogram sequencer: decodes the uop into sequencer controls,
// and tracks stack depth, the loop counter, the RUN/HALTED state and sticky error flags.
module seq_control #(
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  seq_control_if.slave     bus,
  output logic [2:0]       depth,
  output logic [CNT_W-1:0] count,
  output logic             halted,
  output logic             stk_ovf,
  output logic             stk_unf,
  output logic             illegal,
  output logic             state_dbg
);
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  localparam logic [3:0] UOP_JZ   = 4'd0;
  localparam logic [3:0] UOP_CONT = 4'd1;
  localparam logic [3:0] UOP_JMP  = 4'd2;
  localparam logic [3:0] UOP_CJP  = 4'd3;
  localparam logic [3:0] UOP_CJS  = 4'd4;
  localparam logic [3:0] UOP_CRTN = 4'd5;
  localparam logic [3:0] UOP_LDCT = 4'd6;
  localparam logic [3:0] UOP_RPCT = 4'd7;
  localparam logic [3:0] UOP_PUSH = 4'd8;
  localparam logic [3:0] UOP_LDAR = 4'd9;
  localparam logic [3:0] UOP_JAR  = 4'd10;
  localparam logic [3:0] UOP_HALT = 4'd11;

  localparam logic [2:0] DEPTH_MAX = 3'(STACK_DEPTH);

  state_t           state, state_next;
  logic [2:0]       depth_next;
  logic [CNT_W-1:0] count_next;
  logic             ovf_next, unf_next, ill_next;
  logic [1:0]       s;
  logic             zero, cin, re, fe, pup;
  logic             push_req, pop_req;

  always_comb begin
    state_next = state;
    depth_next = depth;
    count_next = count;
    ovf_next   = stk_ovf;
    unf_next   = stk_unf;
    ill_next   = illegal;
    s          = 2'b00;
    zero       = 1'b1;
    cin        = 1'b1;
    re         = 1'b1;
    fe         = 1'b1;
    pup        = 1'b0;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    if (reset) begin
      // Hold the sequencer PC at address 0 while reset is asserted.
      zero = 1'b0;
      cin  = 1'b0;
    end else if (state == HALTED) begin
      cin = 1'b0;
      if (bus.resume) state_next = RUN;
    end else begin
      case (bus.uop)
        UOP_JZ: begin
          zero       = 1'b0;
          cin        = 1'b0;
          depth_next = '0;
        end
        UOP_CONT: ;
        UOP_JMP:  s = 2'b11;
        UOP_CJP:  if (bus.cond) s = 2'b11;
        UOP_CJS: begin
          if (bus.cond) begin
            s        = 2'b11;
            push_req = 1'b1;
          end
        end
        UOP_CRTN: if (bus.cond) pop_req = 1'b1;
        UOP_LDCT: count_next = bus.cnt_in;
        UOP_RPCT: begin
          if (count != '0) begin
            s          = 2'b11;
            count_next = count - CNT_W'(1);
          end
        end
        UOP_PUSH: push_req = 1'b1;
        UOP_LDAR: re = 1'b0;
        UOP_JAR:  s = 2'b01;
        UOP_HALT: begin
          cin        = 1'b0;
          state_next = HALTED;
        end
        default:  ill_next = 1'b1;
      endcase
      // Stack guards: an impossible push/pop leaves fe high and only raises the flag.
      if (push_req) begin
        if (depth == DEPTH_MAX) begin
          ovf_next = 1'b1;
        end else begin
          fe         = 1'b0;
          pup        = 1'b1;
          depth_next = depth + 3'd1;
        end
      end
      if (pop_req) begin
        if (depth == 3'd0) begin
          unf_next = 1'b1;
        end else begin
          s          = 2'b10;
          fe         = 1'b0;
          depth_next = depth - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RUN;
      depth   <= '0;
      count   <= '0;
      stk_ovf <= 1'b0;
      stk_unf <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_next;
      depth   <= depth_next;
      count   <= count_next;
      stk_ovf <= ovf_next;
      stk_unf <= unf_next;
      illegal <= ill_next;
    end
  end

  assign halted    = (state == HALTED);
  assign state_dbg = state;
  assign bus.s1    = s[1];
  assign bus.s0    = s[0];
  assign bus.zero  = zero;
  assign bus.cin   = cin;
  assign bus.re    = re;
  assign bus.fe    = fe;
  assign bus.pup   = pup;
endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 Parameter STACK_DEPTH, default 4, SHALL set the number of sequencer stack entries the block tracks.
REQ-002 Parameter CNT_W, default 8, SHALL set the loop-counter width.
REQ-003 clock  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 uop  in  4  SHALL carry the next-address opcode from the microinstruction pipeline register.
REQ-006 cond  in  1  SHALL carry the selected test condition (1 = true).
REQ-007 cnt_in  in  CNT_W  SHALL carry the counter load value for LDCT.
REQ-008 resume  in  1  SHALL carry a one-cycle pulse that releases HALTED.
REQ-009 s0, s1  out  1 each  SHALL drive the sequencer source select (00 PC, 01 AR, 10 stack, 11 D).
REQ-010 zero  out  1  SHALL be active-low and force the sequencer address to 0.
REQ-011 cin  out  1  SHALL be the sequencer PC increment carry.
REQ-012 re  out  1  SHALL be the active-low address-register load enable.
REQ-013 fe  out  1  SHALL be the active-low stack enable.
REQ-014 pup  out  1  SHALL select stack direction (1 push, 0 pop).
REQ-015 depth  out  3  SHALL report the tracked stack occupancy, 0..STACK_DEPTH.
REQ-016 count  out  CNT_W  SHALL report the loop counter.
REQ-017 halted  out  1  SHALL be high in the HALTED state.
REQ-018 stk_ovf, stk_unf, illegal  out  1 each  SHALL be sticky error flags.

Function
REQ-019 Control outputs SHALL be combinational from uop, cond and registered state; depth, count, flags and FSM state SHALL be registered.
REQ-020 Defaults unless overridden: s=00, zero=1, cin=1, re=1, fe=1, pup=0.
REQ-021 uop 0 JZ: zero=0, cin=0; depth SHALL clear to 0.
REQ-022 uop 1 CONT: defaults.
REQ-023 uop 2 JMP: s=11.
REQ-024 uop 3 CJP: s=11 if cond, else defaults.
REQ-025 uop 4 CJS: if cond, s=11, fe=0, pup=1 and depth+1; else defaults.
REQ-026 uop 5 CRTN: if cond, s=10, fe=0, pup=0 and depth-1; else defaults.
REQ-027 uop 6 LDCT: defaults; count SHALL load cnt_in.
REQ-028 uop 7 RPCT: if count!=0, s=11 and count-1; if count==0, defaults and count holds.
REQ-029 uop 8 PUSH: fe=0, pup=1, depth+1, continue at PC.
REQ-030 uop 9 LDAR: re=0, continue.
REQ-031 uop 10 JAR: s=01.
REQ-032 uop 11 HALT: s=00, cin=0; the FSM SHALL enter HALTED on the next edge.
REQ-033 uop 12-15 SHALL behave as CONT and set illegal.
REQ-034 FSM states are RUN and HALTED. RUN moves to HALTED on HALT. HALTED moves to RUN on the edge where resume=1.
REQ-035 While HALTED, outputs SHALL be s=00, cin=0, zero=1, re=1, fe=1 regardless of uop, and count and depth SHALL hold.
REQ-036 A push with depth==STACK_DEPTH SHALL suppress the stack operation (fe=1) and set stk_ovf; the jump (CJS) SHALL still occur.
REQ-037 A pop with depth==0 SHALL suppress the stack operation, output defaults (continue), and set stk_unf.
REQ-038 Counter SHALL not wrap below 0; LDCT and RPCT in the same cycle is impossible (single uop).
REQ-039 The cond input SHALL be ignored by all uops except CJP, CJS and CRTN.

Reset
REQ-040 While reset=1, outputs SHALL be zero=0, cin=0, s=00, re=1, fe=1, pup=0 (sequencer PC is held at 0).
REQ-041 On reset, depth, count, stk_ovf, stk_unf and illegal SHALL clear, the FSM SHALL enter RUN, and halted SHALL be 0.
REQ-042 Reset asserted mid-HALTED or mid-RPCT loop SHALL take priority over resume and uop on that edge.

Verification
REQ-043 Reset, then CONT x3 -> s=00, cin=1, zero=1 each cycle; depth=0, count=0.
REQ-044 LDCT with cnt_in=3, then RPCT x4 -> s=11 for three cycles (count 2,1,0), then s=00 with count=0.
REQ-045 CJS cond=1 x5 with STACK_DEPTH=4 -> fe=0, pup=1 four times (depth 4); the fifth has fe=1, s=11, and stk_ovf=1.
REQ-046 CRTN cond=1 at depth=0 -> fe=1, s=00, cin=1, stk_unf=1; CRTN cond=0 at depth=2 -> defaults, depth stays 2.
REQ-047 HALT, then JMP with resume=0 for 2 cycles -> halted=1, s=00, cin=0; resume=1 -> RUN, and the next JMP gives s=11.
REQ-048 uop=14 -> CONT outputs, illegal=1 sticky until reset; JZ at depth=3 -> zero=0, depth=0.
